// File: rtl/cvxif_mem_arbiter_if.sv
// Bundle of requester, downstream memory and result signals for cvxif_mem_arbiter.
// slave = arbiter view, master = the requesters/memory environment driving it.
interface cvxif_mem_arbiter_if #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 2
);
  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [NumReq-1:0]                req_valid_i;
  logic [NumReq-1:0]                req_ready_o;
  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i;
  logic [NumReq-1:0]                req_we_i;
  logic [NumReq-1:0][BeWidth-1:0]   req_be_i;
  logic [NumReq-1:0][DataWidth-1:0] req_wdata_i;
  logic [NumReq-1:0][IdWidth-1:0]   req_id_i;

  logic                 mem_valid_o;
  logic                 mem_ready_i;
  logic [AddrWidth-1:0] mem_addr_o;
  logic                 mem_we_o;
  logic [BeWidth-1:0]   mem_be_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic [IdWidth-1:0]   mem_id_o;

  logic                 mem_result_valid_i;
  logic [DataWidth-1:0] mem_result_rdata_i;
  logic [IdWidth-1:0]   mem_result_id_i;
  logic                 mem_result_err_i;

  logic [NumReq-1:0]    rsp_valid_o;
  logic [DataWidth-1:0] rsp_rdata_o;
  logic [IdWidth-1:0]   rsp_id_o;
  logic                 rsp_err_o;

  logic [CntWidth-1:0]  outstanding_o;
  logic                 unexpected_o;
  logic                 id_mismatch_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, req_id_i,
    output req_ready_o,
    output mem_valid_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_id_o,
    input  mem_ready_i,
    input  mem_result_valid_i, mem_result_rdata_i, mem_result_id_i, mem_result_err_i,
    output rsp_valid_o, rsp_rdata_o, rsp_id_o, rsp_err_o,
    output outstanding_o, unexpected_o, id_mismatch_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, req_id_i,
    input  req_ready_o,
    input  mem_valid_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_id_o,
    output mem_ready_i,
    output mem_result_valid_i, mem_result_rdata_i, mem_result_id_i, mem_result_err_i,
    input  rsp_valid_o, rsp_rdata_o, rsp_id_o, rsp_err_o,
    input  outstanding_o, unexpected_o, id_mismatch_o
  );
endinterface

// File: rtl/cvxif_mem_arbiter.sv
// Round-robin arbiter sharing one CV-X-IF memory channel; in-order source FIFO routes results back.
// Optional CVXIF_MEM_ARB_ID_CHECK_EN: check result id against the id stored at accept time.
module cvxif_mem_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  cvxif_mem_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  logic [IdxW-1:0] rr_q, lock_idx_q, win_idx, cand, head_src;
  logic            lock_q, rr_found, mem_hs, pop, unexp_q;
  logic [CntW-1:0] cnt_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [IdxW-1:0] src_q [MaxOutstanding];
  logic [NumReq-1:0] grant_oh, head_oh;

  // Search from the rr pointer with wrap; a stalled grant stays pinned to its requester.
  always_comb begin
    win_idx  = rr_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NumReq);
      if (!rr_found && bus.req_valid_i[cand]) begin
        win_idx  = cand;
        rr_found = 1'b1;
      end
    end
    if (lock_q) win_idx = lock_idx_q;
  end

  assign head_src = src_q[rd_ptr_q];

  for (genvar k = 0; k < NumReq; k++) begin : g_lane
    assign grant_oh[k] = (win_idx == IdxW'(k));
    assign head_oh[k]  = (head_src == IdxW'(k));
  end

  // Full blocks acceptance even when a result frees a slot this cycle.
  assign bus.mem_valid_o = (cnt_q != MaxCnt) && (|bus.req_valid_i);
  assign mem_hs          = bus.mem_valid_o && bus.mem_ready_i;
  assign bus.mem_addr_o  = bus.mem_valid_o ? bus.req_addr_i[win_idx]  : '0;
  assign bus.mem_we_o    = bus.mem_valid_o ? bus.req_we_i[win_idx]    : 1'b0;
  assign bus.mem_be_o    = bus.mem_valid_o ? bus.req_be_i[win_idx]    : '0;
  assign bus.mem_wdata_o = bus.mem_valid_o ? bus.req_wdata_i[win_idx] : '0;
  assign bus.mem_id_o    = bus.mem_valid_o ? bus.req_id_i[win_idx]    : '0;
  assign bus.req_ready_o = mem_hs ? grant_oh : '0;

  assign pop              = bus.mem_result_valid_i && (cnt_q != '0);
  assign bus.rsp_valid_o  = pop ? head_oh : '0;
  assign bus.rsp_rdata_o  = pop ? bus.mem_result_rdata_i : '0;
  assign bus.rsp_id_o     = pop ? bus.mem_result_id_i : '0;
  assign bus.outstanding_o = cnt_q;
  assign bus.unexpected_o = unexp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      unexp_q    <= 1'b0;
    end else begin
      if (mem_hs) begin
        rr_q     <= (win_idx == LastIdx) ? '0 : win_idx + IdxW'(1);
        lock_q   <= 1'b0;
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end else if (bus.mem_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= win_idx;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(mem_hs) - CntW'(pop);
      if (bus.mem_result_valid_i && (cnt_q == '0)) unexp_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_hs) src_q[wr_ptr_q] <= win_idx;
  end

`ifdef CVXIF_MEM_ARB_ID_CHECK_EN
  logic [IdWidth-1:0] id_q [MaxOutstanding];
  logic               id_bad, mism_q;

  assign id_bad = pop && (bus.mem_result_id_i != id_q[rd_ptr_q]);

  always_ff @(posedge clk_i) begin
    if (mem_hs) id_q[wr_ptr_q] <= bus.req_id_i[win_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     mism_q <= 1'b0;
    else if (id_bad) mism_q <= 1'b1;
  end

  assign bus.rsp_err_o     = pop && (bus.mem_result_err_i || id_bad);
  assign bus.id_mismatch_o = mism_q;
`else
  assign bus.rsp_err_o     = pop && bus.mem_result_err_i;
  assign bus.id_mismatch_o = 1'b0;
`endif

  // A requester holding a stalled grant must keep its request up until accepted.
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> bus.req_valid_i[lock_idx_q]);

endmodule

// File: tb/tb_cvxif_mem_arbiter.sv
// Randomized + directed bench for cvxif_mem_arbiter with a queue-based reference model.
module tb_cvxif_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MO = 2;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  cvxif_mem_arbiter_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW),
                         .MaxOutstanding(MO)) bus ();

  cvxif_mem_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW),
                      .MaxOutstanding(MO)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

`ifdef CVXIF_MEM_ARB_ID_CHECK_EN
  localparam bit IdChk = 1'b1;
`else
  localparam bit IdChk = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: outstanding transactions as a queue of (source, id)
  typedef struct { int src; logic [IW-1:0] id; } ent_t;
  ent_t exp_q[$];
  int   grant_log[$];
  int   m_rr, m_lidx;
  bit   m_lock, m_unexp, m_mism;

  always @(negedge clk) begin : monitor
    int cnt, w;
    bit exp_mv, hs, exp_pop, bad_id;
    ent_t e;
    if (!rst_ni) begin
      exp_q.delete(); grant_log.delete();
      m_rr = 0; m_lock = 0; m_lidx = 0; m_unexp = 0; m_mism = 0;
      chk("rst_outstanding", bus.outstanding_o, 0);
      chk("rst_unexpected", bus.unexpected_o, 0);
      chk("rst_id_mismatch", bus.id_mismatch_o, 0);
      chk("rst_mem_valid", bus.mem_valid_o, 0);
      chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    end else begin
      cnt = exp_q.size();
      w = -1;
      if (m_lock) w = m_lidx;
      else for (int i = 0; i < N; i++)
        if (w < 0 && bus.req_valid_i[(m_rr + i) % N]) w = (m_rr + i) % N;
      exp_mv = (cnt < MO) && (bus.req_valid_i != '0);
      hs = exp_mv && bus.mem_ready_i;
      chk("mem_valid", bus.mem_valid_o, exp_mv);
      if (exp_mv) begin
        chk("mem_id", bus.mem_id_o, bus.req_id_i[w]);
        chk("mem_addr", bus.mem_addr_o, bus.req_addr_i[w]);
        chk("mem_wdata", {bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o},
            {bus.req_we_i[w], bus.req_be_i[w], bus.req_wdata_i[w]});
      end else begin
        chk("mem_addr_idle", bus.mem_addr_o, 0);
      end
      chk("req_ready", bus.req_ready_o, hs ? (64'd1 << w) : 64'd0);
      chk("outstanding", bus.outstanding_o, cnt);
      chk("unexpected", bus.unexpected_o, m_unexp);
      chk("id_mismatch", bus.id_mismatch_o, m_mism);

      exp_pop = bus.mem_result_valid_i && (cnt > 0);
      chk("rsp_present", bus.rsp_valid_o != '0, exp_pop);
      if (bus.rsp_valid_o != '0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        bad_id = IdChk && (bus.mem_result_id_i != e.id);
        chk("rsp_route", bus.rsp_valid_o, 64'd1 << e.src);
        chk("rsp_rdata", bus.rsp_rdata_o, bus.mem_result_rdata_i);
        chk("rsp_id", bus.rsp_id_o, bus.mem_result_id_i);
        chk("rsp_err", bus.rsp_err_o, bus.mem_result_err_i | bad_id);
        if (bad_id) m_mism = 1;
      end else if (!exp_pop) begin
        chk("rsp_rdata_idle", bus.rsp_rdata_o, 0);
      end
      if (bus.mem_result_valid_i && cnt == 0) m_unexp = 1;

      if (hs) begin
        e.src = w; e.id = bus.req_id_i[w];
        exp_q.push_back(e);
        grant_log.push_back(w);
        m_rr = (w + 1) % N;
        m_lock = 0;
      end else if (exp_mv) begin
        m_lock = 1; m_lidx = w;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] acc;

  task automatic new_payload(input int k);
    bus.req_addr_i[k]  = AW'($urandom);
    bus.req_we_i[k]    = 1'($urandom);
    bus.req_be_i[k]    = BW'($urandom);
    bus.req_wdata_i[k] = DW'($urandom);
    bus.req_id_i[k]    = IW'($urandom);
  endtask

  task automatic half();
    @(negedge clk);
    acc = bus.req_ready_o;
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (acc[k]) new_payload(k);
  endtask

  task automatic tick();
    half(); fin();
  endtask

  task automatic drive_result(input bit v);
    bus.mem_result_valid_i = v;
    bus.mem_result_rdata_i = v ? DW'($urandom) : '0;
    bus.mem_result_id_i    = (v && exp_q.size() > 0) ? exp_q[0].id : '0;
    bus.mem_result_err_i   = 1'b0;
  endtask

  task automatic zero_inputs();
    bus.req_valid_i = '0;
    for (int k = 0; k < N; k++) new_payload(k);
    bus.mem_ready_i = 1'b0;
    drive_result(1'b0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    zero_inputs();
    tick(); tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    zero_inputs();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Result with empty FIFO straight out of reset
    bus.mem_result_valid_i = 1'b1;
    bus.mem_result_rdata_i = 32'hDEADBEEF;
    half();
    chk("unexp_rsp_valid", bus.rsp_valid_o, 0);
    chk("unexp_rsp_rdata", bus.rsp_rdata_o, 0);
    fin();
    drive_result(1'b0);
    tick(); tick();
    half();
    chk("unexp_sticky", bus.unexpected_o, 1);
    fin();

    // Both requesting, results one cycle after each accept -> alternate grants
    do_reset();
    bus.req_valid_i = 2'b11;
    bus.mem_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      drive_result(acc != '0);
    end
    for (int g = 0; g < 4; g++)
      chk($sformatf("rr_grant%0d", g), (grant_log.size() > g) ? grant_log[g] : -1, g % 2);

    // Stalled grant on req1 stays locked when req0 appears
    do_reset();
    bus.req_valid_i = 2'b10;
    bus.req_id_i[1] = 4'h9;
    tick();
    bus.req_valid_i = 2'b11;
    bus.req_id_i[0] = 4'h2;
    half();
    chk("lock_mem_id", bus.mem_id_o, 4'h9);
    fin();
    bus.mem_ready_i = 1'b1;
    half();
    chk("lock_release_ready", bus.req_ready_o, 2'b10);
    fin();
    bus.req_valid_i = 2'b01;
    half();
    chk("lock_next_grant", bus.req_ready_o, 2'b01);
    fin();
    bus.req_valid_i = '0;

    // Full: no accept even when a result pops the same cycle
    do_reset();
    bus.req_valid_i = 2'b11;
    bus.mem_ready_i = 1'b1;
    tick(); tick();
    drive_result(1'b1);
    half();
    chk("full_outstanding", bus.outstanding_o, 2);
    chk("full_mem_valid", bus.mem_valid_o, 0);
    chk("full_pop_route", bus.rsp_valid_o, 2'b01);
    fin();
    drive_result(1'b0);
    half();
    chk("full_resume", bus.req_ready_o, 2'b01);
    fin();
    bus.req_valid_i = '0;

    // Id check: accept id 3, return id 5
    do_reset();
    bus.req_valid_i = 2'b01;
    bus.req_id_i[0] = 4'h3;
    bus.mem_ready_i = 1'b1;
    tick();
    bus.req_valid_i = '0;
    bus.mem_result_valid_i = 1'b1;
    bus.mem_result_id_i    = 4'h5;
    bus.mem_result_err_i   = 1'b0;
    half();
    chk("idchk_rsp_err", bus.rsp_err_o, IdChk);
    fin();
    drive_result(1'b0);
    half();
    chk("idchk_sticky", bus.id_mismatch_o, IdChk);
    fin();

    // Reset with two outstanding, then a stray result
    do_reset();
    bus.req_valid_i = 2'b11;
    bus.mem_ready_i = 1'b1;
    tick(); tick();
    bus.req_valid_i = '0;
    half();
    chk("prerst_outstanding", bus.outstanding_o, 2);
    fin();
    do_reset();
    bus.mem_result_valid_i = 1'b1;
    half();
    chk("postrst_outstanding", bus.outstanding_o, 0);
    chk("postrst_rsp_valid", bus.rsp_valid_o, 0);
    fin();
    drive_result(1'b0);
    half();
    chk("postrst_unexpected", bus.unexpected_o, 1);
    fin();

    // Random traffic; requesters hold until accepted
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < N; k++)
        if (!bus.req_valid_i[k] || acc[k]) begin
          bus.req_valid_i[k] = ($urandom_range(0, 1) == 1);
          new_payload(k);
        end
      bus.mem_ready_i = ($urandom_range(0, 3) != 0);
      if (exp_q.size() > 0) drive_result($urandom_range(0, 2) == 0);
      else drive_result($urandom_range(0, 39) == 0);
      if (bus.mem_result_valid_i) begin
        bus.mem_result_err_i = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 7) == 0) bus.mem_result_id_i = IW'($urandom);
      end
      if (c == 1500) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
